// File: rtl/bus_mem_responder.sv
// Word RAM target on the shared system bus.
// Decodes its address window, waits, then completes on fc_bus.
module bus_mem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned SIZE_WORDS  = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr_bus,
  inout  wire  [31:0] data_bus,
  input  logic        rd_bus,
  input  logic        wr_bus,
  input  logic [3:0]  data_mask_bus,
  inout  wire         fc_bus
);

  localparam int IW = (SIZE_WORDS > 1) ? $clog2(SIZE_WORDS) : 1;
  localparam logic [32:0] LO_ADDR = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_ADDR = LO_ADDR + (33'(SIZE_WORDS) << 2);
  localparam logic [3:0] CNT_INIT =
    (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_DONE,
    S_HOLD
  } state_t;

  state_t          state;
  logic [3:0]      cnt;
  logic [IW-1:0]   idx_q;
  logic            op_q;
  logic [31:0]     data_q;
  logic [3:0]      mask_q;
  logic [31:0]     rdata_q;
  logic [31:0]     mem [SIZE_WORDS];

  logic            hit;
  logic            req;
  logic            idle_bus;
  logic            accept;
  logic            enter_done;
  logic [31:0]     offs;
  logic [IW-1:0]   idx_bus;
  logic            mem_op;
  logic [IW-1:0]   mem_idx;
  logic [31:0]     mem_wdata;
  logic [3:0]      mem_mask;
  logic            mem_we;
  logic            mem_re;
  logic            unused_ok;

  assign hit = ({1'b0, addr_bus} >= LO_ADDR) &&
               ({1'b0, addr_bus} <  HI_ADDR);
  assign req = (rd_bus ^ wr_bus) && hit;
  assign idle_bus = !rd_bus && !wr_bus;
  assign offs = addr_bus - BASE_ADDR;
  assign idx_bus = offs[IW+1:2];
  assign unused_ok = ^{offs[31:IW+2], offs[1:0]};

  assign accept = (state == S_IDLE) && req;

  // The edge that moves the FSM into DONE is the one that
  // commits a write or captures read data.
  assign enter_done = !rst &&
    ((accept && (WAIT_STATES == 0)) ||
     ((state == S_WAIT) && (cnt == 4'd0) && !idle_bus));

  assign mem_op    = accept ? wr_bus        : op_q;
  assign mem_idx   = accept ? idx_bus       : idx_q;
  assign mem_wdata = accept ? data_bus      : data_q;
  assign mem_mask  = accept ? data_mask_bus : mask_q;
  assign mem_we    = enter_done && mem_op;
  assign mem_re    = enter_done && !mem_op;

  // Bus handshake FSM: accept, count wait states, complete, hold off.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= 4'd0;
      idx_q  <= '0;
      op_q   <= 1'b0;
      data_q <= 32'd0;
      mask_q <= 4'd0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req) begin
            idx_q  <= idx_bus;
            op_q   <= wr_bus;
            data_q <= data_bus;
            mask_q <= data_mask_bus;
            if (WAIT_STATES == 0) begin
              state <= S_DONE;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (idle_bus) begin
            state <= S_IDLE;
          end else if (cnt == 4'd0) begin
            state <= S_DONE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_DONE: begin
          state <= S_HOLD;
        end
        S_HOLD: begin
          if (idle_bus) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Byte-masked storage and read-data capture for the DONE cycle.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_mask[b]) begin
          mem[mem_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
      end
    end
    if (mem_re) begin
      rdata_q <= mem[mem_idx];
    end
  end

  assign fc_bus = (state != S_IDLE) ? (state == S_DONE) : 1'bz;
  assign data_bus = ((state == S_DONE) && !op_q) ? rdata_q : 'z;

endmodule

// File: tb/tb_bus_mem_responder.sv
// Bench: three responders sharing one bus, directed and random
// transactions checked against a word-map model of the windows.
module tb_bus_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr_bus;
  wire  [31:0] data_bus;
  logic        rd_bus;
  logic        wr_bus;
  logic [3:0]  data_mask_bus;
  wire         fc_bus;
  logic        tb_oe;
  logic [31:0] tb_data;

  int checks = 0;
  int fails  = 0;

  logic [31:0] mdl [int unsigned];

  always #5 clk = ~clk;

  assign data_bus = tb_oe ? tb_data : 'z;

  bus_mem_responder #(
    .BASE_ADDR(32'h0000_0000), .SIZE_WORDS(256), .WAIT_STATES(1)
  ) dut_a (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .data_mask_bus(data_mask_bus),
    .fc_bus(fc_bus)
  );

  bus_mem_responder #(
    .BASE_ADDR(32'h0000_1000), .SIZE_WORDS(64), .WAIT_STATES(3)
  ) dut_b (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .data_mask_bus(data_mask_bus),
    .fc_bus(fc_bus)
  );

  bus_mem_responder #(
    .BASE_ADDR(32'h0000_2000), .SIZE_WORDS(16), .WAIT_STATES(0)
  ) dut_c (
    .clk(clk), .rst(rst), .addr_bus(addr_bus), .data_bus(data_bus),
    .rd_bus(rd_bus), .wr_bus(wr_bus), .data_mask_bus(data_mask_bus),
    .fc_bus(fc_bus)
  );

  // Wait states of whichever window holds the address, -1 on a miss.
  function automatic int lat_of(input logic [31:0] a);
    if (a < 32'h400) return 1;
    if (a >= 32'h1000 && a < 32'h1100) return 3;
    if (a >= 32'h2000 && a < 32'h2040) return 0;
    return -1;
  endfunction

  function automatic logic [31:0] fc1();
    return {31'd0, fc_bus === 1'b1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transaction, entered and left just after a falling edge.
  task automatic txn(input bit is_wr, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] m,
                     input int hold);
    int lat;
    int unsigned key;
    logic [31:0] exp_rd;
    logic [31:0] nv;
    lat = lat_of(a);
    key = a >> 2;
    exp_rd = mdl.exists(key) ? mdl[key] : 'x;
    addr_bus = a;
    rd_bus = !is_wr;
    wr_bus = is_wr;
    data_mask_bus = m;
    tb_oe = is_wr || (lat < 0);
    tb_data = is_wr ? wd : 32'd0;
    if (lat < 0) begin
      for (int c = 1; c <= 6; c++) begin
        @(negedge clk);
        chk("miss_fc", fc1(), 32'd0);
        chk("miss_data", data_bus, tb_data);
      end
      rd_bus = 1'b0;
      wr_bus = 1'b0;
      @(negedge clk);
      return;
    end
    for (int c = 1; c <= lat + 1; c++) begin
      @(negedge clk);
      chk("fc_latency", fc1(), {31'd0, c == lat + 1});
      if (c == lat + 1 && !is_wr) chk("rd_data", data_bus, exp_rd);
      if (c == 1) begin
        addr_bus = {a[31:6], 6'($urandom)};
        data_mask_bus = 4'($urandom);
        if (is_wr) tb_data = $urandom;
      end
    end
    if (is_wr) begin
      nv = mdl.exists(key) ? mdl[key] : 'x;
      for (int b = 0; b < 4; b++)
        if (m[b]) nv[8*b +: 8] = wd[8*b +: 8];
      mdl[key] = nv;
    end
    for (int h = 0; h <= hold; h++) begin
      @(posedge clk);
      #1;
      tb_oe = 1'b1;
      tb_data = 32'd0;
      if (h == hold) begin
        rd_bus = 1'b0;
        wr_bus = 1'b0;
      end
      @(negedge clk);
      chk("hold_fc", fc1(), 32'd0);
      chk("hold_data_z", data_bus, 32'd0);
    end
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("idle_fc", fc1(), 32'd0);
    chk("idle_data_z", data_bus, 32'd0);
  endtask

  initial begin
    int w;
    int hold;
    logic [31:0] a;
    logic [3:0] m;

    rst = 1'b1;
    rd_bus = 1'b0;
    wr_bus = 1'b0;
    addr_bus = 32'd0;
    data_mask_bus = 4'd0;
    tb_oe = 1'b1;
    tb_data = 32'd0;
    repeat (2) @(negedge clk);
    chk("reset_fc", fc1(), 32'd0);
    chk("reset_data_z", data_bus, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // write then read back, byte mask, empty mask
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0);
    txn(1'b1, 32'h10, 32'h11223344, 4'b0101, 0);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0);
    chk("mask_value", mdl[32'h10 >> 2], 32'hDE22BE44);
    txn(1'b1, 32'h10, 32'h55555555, 4'h0, 0);
    txn(1'b0, 32'h13, 32'd0, 4'h0, 0);

    // window edges
    txn(1'b0, 32'h0FFC, 32'd0, 4'h0, 0);
    txn(1'b0, 32'h1100, 32'd0, 4'h0, 0);
    txn(1'b1, 32'h1000, 32'hA5A5_0001, 4'hF, 0);
    txn(1'b0, 32'h1000, 32'd0, 4'h0, 0);
    txn(1'b1, 32'h10FC, 32'h0BAD_F00D, 4'hF, 0);
    txn(1'b0, 32'h10FC, 32'd0, 4'h0, 0);
    txn(1'b1, 32'h203C, 32'h7777_8888, 4'hF, 0);
    txn(1'b0, 32'h203C, 32'd0, 4'h0, 0);

    // held request gives one pulse, reassert gives another
    txn(1'b0, 32'h10, 32'd0, 4'h0, 5);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0);

    // abort in WAIT leaves memory untouched
    txn(1'b1, 32'h1020, 32'h1234_5678, 4'hF, 0);
    addr_bus = 32'h1020;
    wr_bus = 1'b1;
    data_mask_bus = 4'hF;
    tb_oe = 1'b1;
    tb_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("abort_wait_fc", fc1(), 32'd0);
    wr_bus = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("abort_fc", fc1(), 32'd0);
    end
    txn(1'b0, 32'h1020, 32'd0, 4'h0, 0);

    // reset in WAIT discards the write
    addr_bus = 32'h1020;
    wr_bus = 1'b1;
    data_mask_bus = 4'hF;
    tb_oe = 1'b1;
    tb_data = 32'hCAFEF00D;
    @(negedge clk);
    chk("rst_wait_fc", fc1(), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    wr_bus = 1'b0;
    tb_data = 32'd0;
    @(negedge clk);
    chk("rst_after_fc", fc1(), 32'd0);
    chk("rst_after_data_z", data_bus, 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_quiet_fc", fc1(), 32'd0);
    end
    txn(1'b0, 32'h1020, 32'd0, 4'h0, 0);

    // rd and wr together are ignored
    addr_bus = 32'h10;
    rd_bus = 1'b1;
    wr_bus = 1'b1;
    data_mask_bus = 4'hF;
    tb_oe = 1'b1;
    tb_data = 32'hFFFF_0000;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("illegal_fc", fc1(), 32'd0);
    end
    rd_bus = 1'b0;
    wr_bus = 1'b0;
    tb_data = 32'd0;
    @(negedge clk);
    txn(1'b0, 32'h10, 32'd0, 4'h0, 0);

    // random traffic over all windows and the gaps
    for (int i = 0; i < 60; i++) begin
      w = $urandom_range(0, 3);
      hold = $urandom_range(0, 2);
      case (w)
        0: a = 32'(4 * $urandom_range(0, 255) + $urandom_range(0, 3));
        1: a = 32'h1000 + 32'(4 * $urandom_range(0, 63));
        2: a = 32'h2000 + 32'(4 * $urandom_range(0, 15) + $urandom_range(0, 3));
        default: a = 32'($urandom_range(32'h400, 32'hFFF));
      endcase
      if (lat_of(a) >= 0 && mdl.exists(a >> 2) && $urandom_range(0, 1) == 1) begin
        txn(1'b0, a, 32'd0, 4'h0, hold);
      end else begin
        m = (lat_of(a) >= 0 && mdl.exists(a >> 2)) ? 4'($urandom) : 4'hF;
        txn(1'b1, a, $urandom, m, hold);
      end
    end

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
